// File: rtl/ir_issue_ctrl_pkg.sv
// Shared types and defaults for the IR-stage issue controller.
// The queue entry layout is kept small: only the fields that the issue
// decision inspects (valid, regfile_we, rd) plus a payload that is carried through.
package ir_issue_ctrl_pkg;

    localparam int NUM_SCALAR_INSTR  = 2;
    localparam int ROB_CREDITS_DEF   = 32;
    localparam int PREG_CREDITS_DEF  = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regfile_we;
    } instr_entry_t;

    typedef struct packed {
        instr_entry_t instr;
    } id_ir_stage_t;

    // One registered slot handed to rename.
    typedef struct packed {
        id_ir_stage_t instr;
        logic         valid;
    } ir_issue_t;

    // An entry consumes a physical register only if it really writes a
    // register other than x0.
    function automatic logic needs_preg(id_ir_stage_t e);
        return e.instr.valid & e.instr.regfile_we & (e.instr.rd != 5'd0);
    endfunction

endpackage

// File: rtl/ir_issue_ctrl_if.sv
// Queue-side and rename-side signals of the issue controller.
//
// Handshake: the queue presents iq_instr whenever iq_empty is low; an entry
// is consumed in the same cycle its read_head bit is high (no ready from
// the queue side). Towards rename, rn_valid marks a slot as carrying an
// instruction; rename accepts it on any cycle where rn_stall is low, and
// while rn_stall is high with any slot valid the slots are held unchanged.
interface ir_issue_ctrl_if;
    import ir_issue_ctrl_pkg::*;

    id_ir_stage_t [1:0] iq_instr;
    logic               iq_empty;
    logic [1:0]         read_head;
    logic               rn_stall;
    id_ir_stage_t [1:0] rn_instr;
    logic [1:0]         rn_valid;

    // Issue controller side.
    modport master (
        input  iq_instr,
        input  iq_empty,
        input  rn_stall,
        output read_head,
        output rn_instr,
        output rn_valid
    );

    // Queue / rename side.
    modport slave (
        output iq_instr,
        output iq_empty,
        output rn_stall,
        input  read_head,
        input  rn_instr,
        input  rn_valid
    );

endinterface

// File: rtl/ir_issue_ctrl_credit_counter.sv
// Credit counter: starts at MAX, takes up to two debits and two credits per
// cycle, and can be reloaded. Going below zero or above MAX means the
// surrounding logic lost track of allocations.
module issue_credit_counter #(
    parameter int MAX = 32,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic [1:0]    dec_i,
    input  logic [1:0]    inc_i,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] RESET_VAL = MAX[CW-1:0];
    localparam logic [CW:0]   MAX_W     = MAX[CW:0];

    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   plus_w;
    logic [CW:0]   sum_w;

    // Next count; one extra bit so that wrap in either direction is visible.
    always_comb begin
        plus_w  = {1'b0, count_q} + {{(CW-1){1'b0}}, inc_i};
        sum_w   = plus_w - {{(CW-1){1'b0}}, dec_i};
        count_d = load_i ? load_val_i : sum_w[CW-1:0];
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    // Credit accounting must never wrap or exceed the pool size.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !load_i) begin
            assert (plus_w >= {{(CW-1){1'b0}}, dec_i})
                else $error("credit underflow: count=%0d dec=%0d inc=%0d", count_q, dec_i, inc_i);
            assert (plus_w < {{(CW-1){1'b0}}, dec_i} || sum_w <= MAX_W)
                else $error("credit overflow: count=%0d dec=%0d inc=%0d", count_q, dec_i, inc_i);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ir_issue_ctrl.sv
// Issue controller between the IR-stage queue and rename. Issues 0, 1 or 2
// head entries in order, strobes the queue in the same cycle, registers the
// issued pair for rename and keeps ROB / physical-register credits so rename
// never receives more than it can allocate.
module ir_issue_ctrl
    import ir_issue_ctrl_pkg::*;
#(
    parameter int ROB_CREDITS  = ROB_CREDITS_DEF,
    parameter int PREG_CREDITS = PREG_CREDITS_DEF,
    parameter int CW = $clog2(((ROB_CREDITS > PREG_CREDITS) ? ROB_CREDITS : PREG_CREDITS) + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    ir_issue_ctrl_if.master bus,
    input  logic [1:0]     rob_ret_i,
    input  logic [1:0]     preg_ret_i,
    input  logic [CW-1:0]  preg_free_i,
    output logic [CW-1:0]  rob_credit_o,
    output logic [CW-1:0]  preg_credit_o
);

    localparam logic [CW-1:0] ROB_FULL = ROB_CREDITS[CW-1:0];

    ir_issue_t [1:0] slots_q, slots_d;
    logic [CW-1:0]   rob_cnt, preg_cnt;
    logic            need0, need1;
    logic [1:0]      need_sum;
    logic            hold;
    logic            issue0, issue1;
    logic [1:0]      rob_dec, preg_dec;

    // Issue decision: in order, gated by backpressure and credits held at
    // the start of the cycle (returns arriving now are not yet usable).
    always_comb begin
        need0    = needs_preg(bus.iq_instr[0]);
        need1    = needs_preg(bus.iq_instr[1]);
        need_sum = {1'b0, need0} + {1'b0, need1};
        hold     = (slots_q[0].valid | slots_q[1].valid) & bus.rn_stall;
        issue0   = ~rst_i & ~flush_i & ~bus.iq_empty & bus.iq_instr[0].instr.valid & ~hold
                 & (rob_cnt != '0)
                 & (preg_cnt >= {{(CW-1){1'b0}}, need0});
        issue1   = issue0 & bus.iq_instr[1].instr.valid
                 & (rob_cnt >= {{(CW-2){1'b0}}, 2'd2})
                 & (preg_cnt >= {{(CW-2){1'b0}}, need_sum});
        rob_dec  = {1'b0, issue0} + {1'b0, issue1};
        preg_dec = {1'b0, issue0 & need0} + {1'b0, issue1 & need1};
    end

    // Next contents of the rename slots: cleared on flush, frozen on hold,
    // otherwise loaded from the queue head with the issue bits as valids.
    always_comb begin
        slots_d = slots_q;
        if (flush_i) begin
            slots_d[0].valid = 1'b0;
            slots_d[1].valid = 1'b0;
        end else if (!hold) begin
            slots_d[0].instr = bus.iq_instr[0];
            slots_d[0].valid = issue0;
            slots_d[1].instr = bus.iq_instr[1];
            slots_d[1].valid = issue1;
        end
    end

    // Rename slot register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    // ROB entries: refilled to the full pool on flush.
    issue_credit_counter #(
        .MAX (ROB_CREDITS),
        .CW  (CW)
    ) u_rob_credit (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (flush_i),
        .load_val_i (ROB_FULL),
        .dec_i      (rob_dec),
        .inc_i      (rob_ret_i),
        .count_o    (rob_cnt)
    );

    // Physical registers: resynchronised to the free list on flush.
    issue_credit_counter #(
        .MAX (PREG_CREDITS),
        .CW  (CW)
    ) u_preg_credit (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (flush_i),
        .load_val_i (preg_free_i),
        .dec_i      (preg_dec),
        .inc_i      (preg_ret_i),
        .count_o    (preg_cnt)
    );

    // Drive the queue strobes and the rename-facing view of the slots.
    always_comb begin
        bus.read_head   = {issue1, issue0};
        bus.rn_instr[0] = slots_q[0].instr;
        bus.rn_instr[1] = slots_q[1].instr;
        bus.rn_valid    = {slots_q[1].valid, slots_q[0].valid};
    end

    assign rob_credit_o  = rob_cnt;
    assign preg_credit_o = preg_cnt;

endmodule

// File: tb/tb_ir_issue_ctrl.sv
// Bench for ir_issue_ctrl: directed scenarios followed by a random run,
// all checked against a counting model of the issue rules.
module tb_ir_issue_ctrl;
    import ir_issue_ctrl_pkg::*;

    localparam int ROB  = 32;
    localparam int PREG = 32;
    localparam int CW   = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [1:0]    rob_ret;
    logic [1:0]    preg_ret;
    logic [CW-1:0] preg_free;
    logic [CW-1:0] rob_credit;
    logic [CW-1:0] preg_credit;

    int passed = 0;
    int total  = 0;

    // Model state: credits as plain integers, expected rename slots.
    int                 m_rob;
    int                 m_preg;
    logic [1:0]         m_valid;
    id_ir_stage_t [1:0] m_instr;

    ir_issue_ctrl_if bus();

    ir_issue_ctrl #(
        .ROB_CREDITS  (ROB),
        .PREG_CREDITS (PREG),
        .CW           (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .bus           (bus),
        .rob_ret_i     (rob_ret),
        .preg_ret_i    (preg_ret),
        .preg_free_i   (preg_free),
        .rob_credit_o  (rob_credit),
        .preg_credit_o (preg_credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Register demand of one entry, straight from the issue rules.
    function automatic int demand(input id_ir_stage_t e);
        return (e.instr.valid && e.instr.regfile_we && e.instr.rd != 5'd0) ? 1 : 0;
    endfunction

    function automatic id_ir_stage_t mk(input logic v, input logic we, input logic [4:0] rd);
        id_ir_stage_t e;
        e.instr.valid      = v;
        e.instr.pc         = $urandom;
        e.instr.opcode     = 7'($urandom_range(0, 127));
        e.instr.rs1        = 5'($urandom_range(0, 31));
        e.instr.rs2        = 5'($urandom_range(0, 31));
        e.instr.rd         = rd;
        e.instr.regfile_we = we;
        return e;
    endfunction

    function automatic id_ir_stage_t rnd_entry();
        logic [4:0] rd;
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        return mk(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), rd);
    endfunction

    // One cycle: decide how many entries may issue, drive, check the strobes,
    // clock, advance the model and check the registered outputs.
    task automatic step(input logic r, input logic f, input id_ir_stage_t s0, input id_ir_stage_t s1,
                        input logic empty, input logic stall, input int rr_req, input int pr_req,
                        input int pfree);
        id_ir_stage_t [1:0] s;
        int   n;
        int   regs;
        int   nk;
        int   rr;
        int   pr;
        logic hold_m;
        logic [1:0] exp_rh;
        s[0]   = s0;
        s[1]   = s1;
        hold_m = (m_valid != 2'b00) && stall;
        n      = 0;
        regs   = 0;
        if (!r && !f && !empty && !hold_m) begin
            for (int k = 0; k < 2; k++) begin
                if (!s[k].instr.valid) break;
                nk = demand(s[k]);
                if (m_rob < k + 1 || m_preg < regs + nk) break;
                regs += nk;
                n++;
            end
        end
        rr = min2(rr_req, ROB - (m_rob - n));
        pr = min2(pr_req, PREG - (m_preg - regs));
        rst          = r;
        flush        = f;
        bus.iq_instr = s;
        bus.iq_empty = empty;
        bus.rn_stall = stall;
        rob_ret      = 2'(rr);
        preg_ret     = 2'(pr);
        preg_free    = CW'(pfree);
        #2;
        exp_rh = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        chk("read_head", 256'(bus.read_head), 256'(exp_rh));
        @(posedge clk);
        if (r) begin
            m_valid = 2'b00;
            m_instr = '0;
            m_rob   = ROB;
            m_preg  = PREG;
        end else if (f) begin
            m_valid = 2'b00;
            m_rob   = ROB;
            m_preg  = pfree;
        end else begin
            if (!hold_m) begin
                m_instr = s;
                m_valid = exp_rh;
            end
            m_rob  = m_rob - n + rr;
            m_preg = m_preg - regs + pr;
        end
        #1;
        chk("rn_valid", 256'(bus.rn_valid), 256'(m_valid));
        chk("rn_instr", 256'(bus.rn_instr), 256'(m_instr));
        chk("rob_credit", 256'(rob_credit), 256'(m_rob));
        chk("preg_credit", 256'(preg_credit), 256'(m_preg));
    endtask

    initial begin
        id_ir_stage_t nil;
        nil     = '0;
        m_rob   = ROB;
        m_preg  = PREG;
        m_valid = 2'b00;
        m_instr = '0;

        // Reset state.
        step(1, 0, nil, nil, 1, 0, 0, 0, 0);
        step(1, 0, mk(1, 1, 5'd3), mk(1, 1, 5'd4), 0, 0, 0, 0, 0);

        // Two register-writing heads issue together.
        step(0, 0, mk(1, 1, 5'd3), mk(1, 1, 5'd4), 0, 0, 0, 0, 0);
        step(0, 0, nil, nil, 1, 0, 0, 0, 0);

        // Drain ROB credit to 1 with x0 writers, then hit the ROB limit.
        step(0, 1, nil, nil, 1, 0, 0, 0, 32);
        for (int i = 0; i < 15; i++) step(0, 0, mk(1, 1, 5'd0), mk(1, 0, 5'd7), 0, 0, 0, 0, 0);
        step(0, 0, mk(1, 0, 5'd1), nil, 0, 0, 0, 0, 0);
        step(0, 0, mk(1, 0, 5'd1), mk(1, 0, 5'd2), 0, 0, 0, 0, 0);
        step(0, 0, mk(1, 0, 5'd2), mk(1, 0, 5'd3), 0, 0, 2, 0, 0);
        step(0, 0, mk(1, 0, 5'd2), mk(1, 0, 5'd3), 0, 0, 0, 0, 0);

        // Rename stall with a full slot pair holds everything for 3 cycles.
        step(0, 1, nil, nil, 1, 0, 0, 0, 32);
        step(0, 0, mk(1, 1, 5'd8), mk(1, 1, 5'd9), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, mk(1, 1, 5'd10), mk(1, 1, 5'd11), 0, 1, 0, 0, 0);
        step(0, 0, mk(1, 1, 5'd10), mk(1, 1, 5'd11), 0, 0, 0, 0, 0);

        // One free register: x0 + x5 both issue; x3 + x5 only slot 0.
        step(0, 1, nil, nil, 1, 0, 0, 0, 1);
        step(0, 0, mk(1, 1, 5'd0), mk(1, 1, 5'd5), 0, 0, 0, 0, 0);
        step(0, 1, nil, nil, 1, 0, 0, 0, 1);
        step(0, 0, mk(1, 1, 5'd3), mk(1, 1, 5'd5), 0, 0, 0, 0, 0);

        // Flush with valid heads and pending returns.
        step(0, 0, mk(1, 1, 5'd6), mk(1, 1, 5'd7), 0, 0, 0, 0, 0);
        step(0, 1, mk(1, 1, 5'd6), mk(1, 1, 5'd7), 0, 0, 2, 2, 20);

        // Reset during a stalled, full slot pair.
        step(0, 0, mk(1, 1, 5'd12), mk(1, 1, 5'd13), 0, 0, 0, 0, 0);
        step(0, 0, mk(1, 1, 5'd14), mk(1, 1, 5'd15), 0, 1, 0, 0, 0);
        step(1, 0, mk(1, 1, 5'd14), mk(1, 1, 5'd15), 0, 1, 0, 0, 0);
        step(0, 0, nil, nil, 1, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 29) == 0),
                 rnd_entry(), rnd_entry(),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 32));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
